// File: rtl/rock_mode_scheduler.sv
// rock_mode_scheduler: settle/measure/decide hill-climb of rocking amplitude and frequency.
// Optional SEARCH_TIMEOUT_EN adds a decision watchdog that restarts the search.
module rock_mode_scheduler #(
    parameter int AW = 3,
    parameter int FW = 3,
    parameter int AMP_INIT = 2,
    parameter int FREQ_INIT = 2,
    parameter int SETTLE_TICKS = 4,
    parameter int MEAS_TICKS = 2,
    parameter int CALM_COUNT = 3
`ifdef SEARCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_DECISIONS = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          slowClk,
    input  logic          aan,
    input  logic          stressLaag,
    input  logic          stressGelijk,
    output logic [AW-1:0] ampl,
    output logic [FW-1:0] freq,
    output logic          meetVenster,
    output logic          rustig,
    output logic [2:0]    fsmState,
    output logic          timeout
);
    localparam int CW = $clog2(SETTLE_TICKS + MEAS_TICKS + 1);
    localparam int KW = $clog2(CALM_COUNT + 1);
    localparam logic [AW-1:0] A_MAX = '1;
    localparam logic [FW-1:0] F_MAX = '1;

    typedef enum logic [2:0] {IDLE = 3'd0, SETTLE = 3'd1, MEASURE = 3'd2, DECIDE = 3'd3, HOLD = 3'd4} state_t;

    state_t        state;
    logic          slow_q, tick, worse, dir, param, s_dir, s_param, lim, n_dir, calm_hit;
    logic [CW-1:0] cnt;
    logic [KW-1:0] calm, calm_n;
    logic [AW-1:0] a_nx;
    logic [FW-1:0] f_nx;
`ifdef SEARCH_TIMEOUT_EN
    localparam int DW = $clog2(TIMEOUT_DECISIONS + 1);
    logic [DW-1:0] dec;
`else
    assign timeout = 1'b0;
`endif

    assign fsmState = state;

    // a worse verdict flips direction and switches parameter before the step; limits bounce
    always_comb begin
        tick = slowClk & ~slow_q;
        worse = ~stressLaag & ~stressGelijk;
        s_dir = worse ? ~dir : dir;
        s_param = worse ? ~param : param;
        lim = s_param ? (freq == (s_dir ? F_MAX : '0)) : (ampl == (s_dir ? A_MAX : '0));
        n_dir = lim ? ~s_dir : s_dir;
        a_nx = s_param ? ampl : (n_dir ? ampl + AW'(1) : ampl - AW'(1));
        f_nx = s_param ? (n_dir ? freq + FW'(1) : freq - FW'(1)) : freq;
        calm_n = calm + KW'(1);
        calm_hit = stressGelijk & ~stressLaag & (calm_n == KW'(CALM_COUNT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            slow_q <= 1'b0;
            ampl <= AW'(AMP_INIT);
            freq <= FW'(FREQ_INIT);
            meetVenster <= 1'b0;
            rustig <= 1'b0;
            dir <= 1'b1;
            param <= 1'b0;
            cnt <= '0;
            calm <= '0;
`ifdef SEARCH_TIMEOUT_EN
            dec <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            slow_q <= slowClk;
`ifdef SEARCH_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (!aan && state != IDLE) begin
                state <= IDLE;
                meetVenster <= 1'b0;
                rustig <= 1'b0;
                cnt <= '0;
                calm <= '0;
`ifdef SEARCH_TIMEOUT_EN
                dec <= '0;
`endif
            end else begin
                case (state)
                    IDLE: if (tick && aan) begin
                        state <= SETTLE;
                        cnt <= '0;
                    end
                    SETTLE: if (tick) begin
                        cnt <= (cnt == CW'(SETTLE_TICKS - 1)) ? '0 : cnt + CW'(1);
                        state <= (cnt == CW'(SETTLE_TICKS - 1)) ? MEASURE : SETTLE;
                        meetVenster <= (cnt == CW'(SETTLE_TICKS - 1));
                    end
                    MEASURE: if (tick) begin
                        cnt <= (cnt == CW'(MEAS_TICKS - 1)) ? '0 : cnt + CW'(1);
                        state <= (cnt == CW'(MEAS_TICKS - 1)) ? DECIDE : MEASURE;
                        meetVenster <= (cnt != CW'(MEAS_TICKS - 1));
                    end
                    DECIDE: begin
                        cnt <= '0;
                        calm <= (stressGelijk && !stressLaag) ? calm_n : '0;
                        state <= calm_hit ? HOLD : SETTLE;
                        rustig <= calm_hit;
                        if (!calm_hit) begin
                            ampl <= a_nx;
                            freq <= f_nx;
                            dir <= n_dir;
                            param <= s_param;
                        end
`ifdef SEARCH_TIMEOUT_EN
                        dec <= calm_hit ? '0 : dec + DW'(1);
                        if (dec == DW'(TIMEOUT_DECISIONS - 1)) begin
                            state <= SETTLE;
                            rustig <= 1'b0;
                            calm <= '0;
                            dec <= '0;
                            ampl <= AW'(AMP_INIT);
                            freq <= FW'(FREQ_INIT);
                            dir <= 1'b1;
                            param <= 1'b0;
                            timeout <= 1'b1;
                        end
`endif
                    end
                    HOLD: if (tick && worse) begin
                        state <= SETTLE;
                        rustig <= 1'b0;
                        calm <= '0;
                        cnt <= '0;
                        ampl <= a_nx;
                        freq <= f_nx;
                        dir <= n_dir;
                        param <= s_param;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
